// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: splits the 10 instruction bytes into decode fields,
// predicts the next PC, and holds the F (predicted PC) and D pipeline registers.
module fetch_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] f_pc_i,
    output logic [63:0] imem_addr_o,
    input  logic [79:0] imem_instr_i,
    input  logic        imem_error_i,
    input  logic        F_stall_i,
    input  logic        D_stall_i,
    input  logic        D_bubble_i,
    output logic [63:0] F_predPC_o,
    output logic [2:0]  D_stat_o,
    output logic [3:0]  D_icode_o,
    output logic [3:0]  D_ifun_o,
    output logic [3:0]  D_rA_o,
    output logic [3:0]  D_rB_o,
    output logic [63:0] D_valC_o,
    output logic [63:0] D_valP_o
);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    logic [3:0]  icode, ifun, ra, rb;
    logic        instr_valid, need_regids, need_valc;
    logic [63:0] valc, valp, pred_pc;
    logic [2:0]  stat;

    assign imem_addr_o = f_pc_i;

    always_comb begin
        icode = imem_instr_i[7:4];
        ifun  = imem_instr_i[3:0];
        if (imem_error_i) begin
            icode = I_NOP;
            ifun  = 4'h0;
        end

        instr_valid = (icode <= I_POPQ);

        need_regids = (icode == I_RRMOVQ) || (icode == I_IRMOVQ) ||
                      (icode == I_RMMOVQ) || (icode == I_MRMOVQ) ||
                      (icode == I_OPQ)    || (icode == I_PUSHQ)  ||
                      (icode == I_POPQ);

        need_valc = (icode == I_IRMOVQ) || (icode == I_RMMOVQ) ||
                    (icode == I_MRMOVQ) || (icode == I_JXX)    ||
                    (icode == I_CALL);

        ra = R_NONE;
        rb = R_NONE;
        if (need_regids) begin
            ra = imem_instr_i[15:12];
            rb = imem_instr_i[11:8];
        end

        // The constant starts right after the register byte when there is one
        valc = 64'd0;
        if (need_valc)
            valc = need_regids ? imem_instr_i[79:16] : imem_instr_i[71:8];

        valp = f_pc_i + 64'd1 + {63'd0, need_regids} + {60'd0, need_valc, 3'd0};

        pred_pc = ((icode == I_JXX) || (icode == I_CALL)) ? valc : valp;

        if (imem_error_i)
            stat = S_ADR;
        else if (!instr_valid)
            stat = S_INS;
        else if (icode == I_HALT)
            stat = S_HLT;
        else
            stat = S_AOK;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            F_predPC_o <= 64'd0;
        else if (!F_stall_i)
            F_predPC_o <= pred_pc;
    end

    // Reset and bubble both load a NOP so decode sees a harmless instruction
    always_ff @(posedge clk_i) begin
        if (rst_i || (!D_stall_i && D_bubble_i)) begin
            D_stat_o  <= S_AOK;
            D_icode_o <= I_NOP;
            D_ifun_o  <= 4'h0;
            D_rA_o    <= R_NONE;
            D_rB_o    <= R_NONE;
            D_valC_o  <= 64'd0;
            D_valP_o  <= 64'd0;
        end else if (!D_stall_i) begin
            D_stat_o  <= stat;
            D_icode_o <= icode;
            D_ifun_o  <= ifun;
            D_rA_o    <= ra;
            D_rB_o    <= rb;
            D_valC_o  <= valc;
            D_valP_o  <= valp;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [63:0] f_pc_i;
    logic [63:0] imem_addr_o;
    logic [79:0] imem_instr_i;
    logic        imem_error_i;
    logic        F_stall_i, D_stall_i, D_bubble_i;
    logic [63:0] F_predPC_o;
    logic [2:0]  D_stat_o;
    logic [3:0]  D_icode_o, D_ifun_o, D_rA_o, D_rB_o;
    logic [63:0] D_valC_o, D_valP_o;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .f_pc_i       (f_pc_i),
        .imem_addr_o  (imem_addr_o),
        .imem_instr_i (imem_instr_i),
        .imem_error_i (imem_error_i),
        .F_stall_i    (F_stall_i),
        .D_stall_i    (D_stall_i),
        .D_bubble_i   (D_bubble_i),
        .F_predPC_o   (F_predPC_o),
        .D_stat_o     (D_stat_o),
        .D_icode_o    (D_icode_o),
        .D_ifun_o     (D_ifun_o),
        .D_rA_o       (D_rA_o),
        .D_rB_o       (D_rB_o),
        .D_valC_o     (D_valC_o),
        .D_valP_o     (D_valP_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] stat, input logic [3:0] icode,
                             input logic [3:0] ifun, input logic [3:0] ra, input logic [3:0] rb,
                             input logic [63:0] valc, input logic [63:0] valp,
                             input logic [63:0] pred);
        check({tag, ".stat"},  {61'd0, D_stat_o},  {61'd0, stat});
        check({tag, ".icode"}, {60'd0, D_icode_o}, {60'd0, icode});
        check({tag, ".ifun"},  {60'd0, D_ifun_o},  {60'd0, ifun});
        check({tag, ".rA"},    {60'd0, D_rA_o},    {60'd0, ra});
        check({tag, ".rB"},    {60'd0, D_rB_o},    {60'd0, rb});
        check({tag, ".valC"},  D_valC_o,           valc);
        check({tag, ".valP"},  D_valP_o,           valp);
        check({tag, ".predPC"}, F_predPC_o,        pred);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i        = 1'b1;
        f_pc_i       = 64'h0;
        imem_instr_i = 80'h0;
        imem_error_i = 1'b0;
        F_stall_i    = 1'b0;
        D_stall_i    = 1'b0;
        D_bubble_i   = 1'b0;

        tick();
        check_all("reset", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0);

        // irmovq $0x10, %rbx
        rst_i = 1'b0;
        f_pc_i = 64'h0;
        imem_instr_i = 80'h0000_0000_0000_0010_F330;
        #1;
        check("imem_addr", imem_addr_o, 64'h0);
        tick();
        check_all("irmovq", 3'd1, 4'h3, 4'h0, 4'hF, 4'h3, 64'h10, 64'hA, 64'hA);

        // jmp 0x40
        f_pc_i = 64'h20;
        imem_instr_i = 80'h0000_0000_0000_0000_4070;
        tick();
        check_all("jmp", 3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h29, 64'h40);

        // stall both registers for two cycles with a bubble request present
        F_stall_i = 1'b1;
        D_stall_i = 1'b1;
        D_bubble_i = 1'b1;
        f_pc_i = 64'h100;
        imem_instr_i = 80'h0000_0000_0000_0055_F130;
        tick();
        check_all("stall1", 3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h29, 64'h40);
        f_pc_i = 64'h180;
        tick();
        check_all("stall2", 3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h29, 64'h40);

        // bubble: D gets NOP, F still advances
        F_stall_i = 1'b0;
        D_stall_i = 1'b0;
        f_pc_i = 64'h100;
        imem_instr_i = 80'h10;
        tick();
        check_all("bubble", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h101);

        // mrmovq 0x1122334455667788(%rdx), %rcx
        D_bubble_i = 1'b0;
        f_pc_i = 64'h40;
        imem_instr_i = 80'h1122_3344_5566_7788_1250;
        tick();
        check_all("mrmovq", 3'd1, 4'h5, 4'h0, 4'h1, 4'h2, 64'h1122334455667788, 64'h4A, 64'h4A);

        // subq %rdx, %rbx
        f_pc_i = 64'h60;
        imem_instr_i = 80'h23_61;
        tick();
        check_all("opq", 3'd1, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h62, 64'h62);

        // call 0x0102030405060708
        f_pc_i = 64'h70;
        imem_instr_i = 80'h0001_0203_0405_0607_0880;
        tick();
        check_all("call", 3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h0102030405060708, 64'h79, 64'h0102030405060708);

        // invalid opcode
        f_pc_i = 64'h200;
        imem_instr_i = 80'hFFFF_C0;
        tick();
        check_all("invalid", 3'd4, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h201, 64'h201);

        // memory error overrides the fetched opq
        imem_error_i = 1'b1;
        f_pc_i = 64'h300;
        imem_instr_i = 80'h23_60;
        tick();
        check_all("imem_err", 3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h301, 64'h301);

        // halt
        imem_error_i = 1'b0;
        f_pc_i = 64'h400;
        imem_instr_i = 80'h00;
        tick();
        check_all("halt", 3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h401, 64'h401);

        // reset wins during a stall
        F_stall_i = 1'b1;
        D_stall_i = 1'b1;
        rst_i = 1'b1;
        tick();
        check_all("rst_stall", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0);

        // PC wrap on a NOP at the top of the address space
        rst_i = 1'b0;
        F_stall_i = 1'b0;
        D_stall_i = 1'b0;
        f_pc_i = 64'hFFFF_FFFF_FFFF_FFFF;
        imem_instr_i = 80'h10;
        tick();
        check_all("wrap", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
